rsp_s2_chirp_sched: RTL and testbench

Sequencer for the S2 preprocessing core. It runs the core once per chirp across a programmed number of chirps and frames, and keeps the core's AXI read and write base addresses stable for each pass. It alternates ping-pong buffers between passes and pulses frame and sequence completion. It sits between the register bank and the core's `i_start`/`o_finish` pair and shares the core's clock domain.

---
 rtl/rsp_s2_sched_pkg.sv | 24 ++
 rtl/rsp_s2_sched_idx.sv | 40 ++++
 rtl/rsp_s2_chirp_sched.sv | 177 +++++++++++++++++
 tb/tb_rsp_s2_chirp_sched.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsp_s2_sched_pkg.sv
// Shared constants and state encoding for the S2 chirp/frame sequencer.
package rsp_s2_sched_pkg;

    localparam int CHP_W = 10;
    localparam int FRM_W = 4;
    localparam int ST_W  = 3;

    localparam int unsigned DEF_RD_BASE     = 32'd0;
    localparam int unsigned DEF_WR_BASE     = 32'd16384;
    localparam int unsigned DEF_BUF_STRIDE  = 32'd32768;
    localparam int unsigned DEF_GAP_CYC     = 32'd50;
    localparam int unsigned DEF_TIMEOUT_CYC = 32'd65535;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_ERR   = 3'd5,
        ST_DONE  = 3'd6
    } sched_state_e;

endpackage

// File: rtl/rsp_s2_sched_idx.sv
// Chirp/frame index counter for the S2 sequencer; reports last-chirp, last-frame and wrap.
module rsp_s2_sched_idx
    import rsp_s2_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    input  logic [CHP_W-1:0] chp_cnt,
    input  logic [FRM_W-1:0] frm_cnt,
    output logic [CHP_W-1:0] chp_idx,
    output logic [FRM_W-1:0] frm_idx,
    output logic             chp_last,
    output logic             frm_last,
    output logic             chp_wrap
);

    assign chp_last = (chp_idx == chp_cnt - 1'b1);
    assign frm_last = (frm_idx == frm_cnt - 1'b1);
    assign chp_wrap = adv && chp_last;

    // The frame index also wraps after the final frame so a finished run leaves both at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chp_idx <= '0;
            frm_idx <= '0;
        end else if (clr) begin
            chp_idx <= '0;
            frm_idx <= '0;
        end else if (adv) begin
            if (chp_last) begin
                chp_idx <= '0;
                frm_idx <= frm_last ? '0 : frm_idx + 1'b1;
            end else begin
                chp_idx <= chp_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rsp_s2_chirp_sched.sv
// S2 core sequencer: one core pass per chirp over frames, with ping-pong buffer bases.
// Optional WAIT watchdog enabled by defining RSP_S2_SCHED_TIMEOUT_EN.
module rsp_s2_chirp_sched
    import rsp_s2_sched_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RD_BASE     = ADDR_W'(DEF_RD_BASE),
    parameter logic [ADDR_W-1:0] WR_BASE     = ADDR_W'(DEF_WR_BASE),
    parameter logic [ADDR_W-1:0] BUF_STRIDE  = ADDR_W'(DEF_BUF_STRIDE),
    parameter int unsigned       GAP_CYC     = DEF_GAP_CYC,
    parameter int unsigned       TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [CHP_W-1:0]  i_chp_cnt,
    input  logic [FRM_W-1:0]  i_frm_cnt,
    input  logic              i_pingpong_en,
    output logic              o_core_start,
    input  logic              i_core_finish,
    output logic [ADDR_W-1:0] o_rd_base,
    output logic [ADDR_W-1:0] o_wr_base,
    output logic [CHP_W-1:0]  o_chp_idx,
    output logic [FRM_W-1:0]  o_frm_idx,
    output logic              o_busy,
    output logic              o_frm_done,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [ST_W-1:0] S_IDLE  = ST_IDLE;
    localparam logic [ST_W-1:0] S_LOAD  = ST_LOAD;
    localparam logic [ST_W-1:0] S_START = ST_START;
    localparam logic [ST_W-1:0] S_WAIT  = ST_WAIT;
    localparam logic [ST_W-1:0] S_GAP   = ST_GAP;
    localparam logic [ST_W-1:0] S_ERR   = ST_ERR;
    localparam logic [ST_W-1:0] S_DONE  = ST_DONE;

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_nxt;
    logic [CHP_W-1:0]  chp_cnt_q;
    logic [FRM_W-1:0]  frm_cnt_q;
    logic              pp_q;
    logic              sel;
    logic              sel_nxt;
    logic              abort_q;
    logic [15:0]       gap_cnt;
    logic              gap_end;
    logic              err_q;
    logic              frm_done_q;
    logic [ADDR_W-1:0] rd_base_q;
    logic [ADDR_W-1:0] wr_base_q;
    logic              finish_evt;
    logic              chp_last;
    logic              frm_last;
    logic              chp_wrap;
    logic              wd_hit;

    assign finish_evt = (state == S_WAIT) && i_core_finish;
    assign sel_nxt    = sel ^ pp_q;
    assign gap_end    = (gap_cnt == 16'(GAP_CYC - 1));

    rsp_s2_sched_idx u_idx (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == S_LOAD),
        .adv      (finish_evt),
        .chp_cnt  (chp_cnt_q),
        .frm_cnt  (frm_cnt_q),
        .chp_idx  (o_chp_idx),
        .frm_idx  (o_frm_idx),
        .chp_last (chp_last),
        .frm_last (frm_last),
        .chp_wrap (chp_wrap)
    );

`ifdef RSP_S2_SCHED_TIMEOUT_EN
    logic [15:0] wd_cnt;

    assign wd_hit = (state == S_WAIT) && (wd_cnt == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == S_START) begin
            wd_cnt <= '0;
        end else if ((state == S_WAIT) && !wd_hit) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end
`else
    logic unused_timeout;

    assign wd_hit         = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    // A finish in WAIT always takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = ((i_chp_cnt == '0) || (i_frm_cnt == '0)) ? S_ERR : S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_core_finish) begin
                    if ((chp_last && frm_last) || abort_q || i_abort) state_nxt = S_DONE;
                    else                                              state_nxt = S_GAP;
                end else if (wd_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_GAP:   if (gap_end) state_nxt = S_START;
            S_ERR:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            gap_cnt    <= '0;
            frm_done_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            gap_cnt    <= (state == S_GAP) ? gap_cnt + 16'd1 : '0;
            frm_done_q <= chp_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chp_cnt_q <= '0;
            frm_cnt_q <= '0;
            pp_q      <= 1'b0;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
        end else if (state == S_LOAD) begin
            chp_cnt_q <= i_chp_cnt;
            frm_cnt_q <= i_frm_cnt;
            pp_q      <= i_pingpong_en;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if ((state != S_IDLE) && i_abort) abort_q <= 1'b1;
            if (state == S_ERR)               err_q   <= 1'b1;
        end
    end

    // Bases are also reloaded in LOAD so a new run never inherits buffer 1 from the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel       <= 1'b0;
            rd_base_q <= RD_BASE;
            wr_base_q <= WR_BASE;
        end else if (state == S_LOAD) begin
            sel       <= 1'b0;
            rd_base_q <= RD_BASE;
            wr_base_q <= WR_BASE;
        end else if (finish_evt) begin
            sel       <= sel_nxt;
            rd_base_q <= RD_BASE + (sel_nxt ? BUF_STRIDE : '0);
            wr_base_q <= WR_BASE + (sel_nxt ? BUF_STRIDE : '0);
        end
    end

    assign o_core_start = (state == S_START);
    assign o_busy       = (state != S_IDLE);
    assign o_done       = (state == S_DONE);
    assign o_frm_done   = frm_done_q;
    assign o_err        = err_q;
    assign o_rd_base    = rd_base_q;
    assign o_wr_base    = wr_base_q;

endmodule

// File: tb/tb_rsp_s2_chirp_sched.sv
// Scoreboard bench for rsp_s2_chirp_sched with a fixed-latency core model.
module tb_rsp_s2_chirp_sched;

    localparam int CORE_LAT = 100;
    localparam int SPACING  = CORE_LAT + 1 + 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [9:0]  i_chp_cnt = '0;
    logic [3:0]  i_frm_cnt = '0;
    logic        i_pingpong_en = 1'b0;
    logic        o_core_start;
    logic        i_core_finish;
    logic [31:0] o_rd_base;
    logic [31:0] o_wr_base;
    logic [9:0]  o_chp_idx;
    logic [3:0]  o_frm_idx;
    logic        o_busy;
    logic        o_frm_done;
    logic        o_done;
    logic        o_err;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   core_cnt = 0;
    logic core_fin = 1'b0;
    logic core_en = 1'b1;
    logic stray_fin = 1'b0;
    int   fin_total = 0;
    int   fin_edge = 0;

    assign i_core_finish = core_fin | stray_fin;

    rsp_s2_chirp_sched #(.TIMEOUT_CYC(200)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_chp_cnt     (i_chp_cnt),
        .i_frm_cnt     (i_frm_cnt),
        .i_pingpong_en (i_pingpong_en),
        .o_core_start  (o_core_start),
        .i_core_finish (i_core_finish),
        .o_rd_base     (o_rd_base),
        .o_wr_base     (o_wr_base),
        .o_chp_idx     (o_chp_idx),
        .o_frm_idx     (o_frm_idx),
        .o_busy        (o_busy),
        .o_frm_done    (o_frm_done),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: finish pulse sampled CORE_LAT edges after the start pulse is sampled.
    always @(negedge clk) begin
        core_fin = 1'b0;
        if (!rst_n) begin
            core_cnt = 0;
        end else begin
            if (core_cnt > 0) begin
                core_cnt = core_cnt - 1;
                if (core_cnt == 0) begin
                    core_fin  = 1'b1;
                    fin_total = fin_total + 1;
                    fin_edge  = cyc + 1;
                end
            end
            if (o_core_start && core_en) core_cnt = CORE_LAT;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(output int c);
        step();
        c = cyc;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc, output int nst);
        dcyc = -1;
        nst  = 0;
        for (int k = 0; k < budget; k++) begin
            if (o_core_start) nst++;
            if (o_done) begin
                dcyc = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++;
        if ({o_core_start, o_busy, o_done, o_frm_done, o_err} !== 5'b0)
            $display("[TB] FAIL reset_flags: got %b expected 00000", {o_core_start, o_busy, o_done, o_frm_done, o_err});
        if ({o_core_start, o_busy, o_done, o_frm_done, o_err} !== 5'b0) errors++;
        checks++;
        if (o_rd_base !== 32'd0 || o_wr_base !== 32'd16384) begin
            errors++;
            $display("[TB] FAIL reset_bases: got rd=%0d wr=%0d expected rd=0 wr=16384", o_rd_base, o_wr_base);
        end
        checks++;
        if (o_chp_idx !== 10'd0 || o_frm_idx !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_idx: got chp=%0d frm=%0d expected 0 0", o_chp_idx, o_frm_idx);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_main();
        logic [31:0] exp_q[$];
        int          frm_q[$];
        logic [31:0] e;
        int          c0, n_st, prev_st, fin0, ef;
        bit          seen_done;
        i_chp_cnt = 10'd2;
        i_frm_cnt = 4'd2;
        i_pingpong_en = 1'b1;
        core_en = 1'b1;
        fin0 = fin_total;
        n_st = 0;
        prev_st = 0;
        seen_done = 0;
        exp_q.push_back(32'd16384);
        exp_q.push_back(32'd49152);
        exp_q.push_back(32'd16384);
        exp_q.push_back(32'd49152);
        frm_q.push_back(2);
        frm_q.push_back(4);
        pulse_start(c0);
        for (int k = 0; k < 1000 && !seen_done; k++) begin
            if (o_core_start) begin
                checks++;
                if (n_st == 0 && cyc != c0 + 2) begin
                    errors++;
                    $display("[TB] FAIL main_first_start: got cycle %0d expected %0d", cyc, c0 + 2);
                end else if (n_st > 0 && cyc - prev_st != SPACING) begin
                    errors++;
                    $display("[TB] FAIL main_spacing: got %0d expected %0d", cyc - prev_st, SPACING);
                end
                prev_st = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL main_extra_start: got start %0d expected 4 starts", n_st + 1);
                end else begin
                    e = exp_q.pop_front();
                    if (o_wr_base !== e || o_rd_base !== e - 32'd16384) begin
                        errors++;
                        $display("[TB] FAIL main_base: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
                                 o_wr_base, o_rd_base, e, e - 32'd16384);
                    end
                end
                n_st++;
            end
            if (o_frm_done) begin
                checks++;
                ef = (frm_q.size() > 0) ? frm_q.pop_front() : -1;
                if (fin_total - fin0 != ef) begin
                    errors++;
                    $display("[TB] FAIL main_frm_done: got after finish %0d expected %0d", fin_total - fin0, ef);
                end
            end
            if (o_done) begin
                seen_done = 1;
                checks++;
                if (cyc != fin_edge || o_err !== 1'b0 || fin_total - fin0 != 4) begin
                    errors++;
                    $display("[TB] FAIL main_done: got cyc=%0d err=%b fins=%0d expected cyc=%0d err=0 fins=4",
                             cyc, o_err, fin_total - fin0, fin_edge);
                end
            end
            step();
        end
        checks++;
        if (!seen_done || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL main_end: got done_seen=%0d busy=%b expected 1 0", seen_done, o_busy);
        end
        checks++;
        if (n_st != 4 || frm_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL main_counts: got starts=%0d frm_left=%0d expected 4 0", n_st, frm_q.size());
        end
    endtask

    task automatic test_zero_count();
        logic [31:0] exp_q[$];
        logic [31:0] e;
        int c0, d, nst;
        i_chp_cnt = 10'd0;
        i_frm_cnt = 4'd2;
        i_pingpong_en = 1'b0;
        pulse_start(c0);
        wait_done(50, d, nst);
        checks++;
        if (d != c0 + 3 || o_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_done: got cyc=%0d err=%b expected cyc=%0d err=1", d, o_err, c0 + 3);
        end
        checks++;
        if (nst != 0) begin
            errors++;
            $display("[TB] FAIL zero_no_start: got %0d starts expected 0", nst);
        end
        i_chp_cnt = 10'd1;
        i_frm_cnt = 4'd1;
        exp_q.push_back(32'd16384);
        pulse_start(c0);
        step();
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_err_clear: got %b expected 0", o_err);
        end
        checks++;
        e = exp_q.pop_front();
        if (o_core_start !== 1'b1 || o_wr_base !== e) begin
            errors++;
            $display("[TB] FAIL zero_restart: got start=%b wr=%0d expected 1 %0d", o_core_start, o_wr_base, e);
        end
        wait_done(400, d, nst);
        checks++;
        if (d < 0 || o_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_restart_done: got done_cyc=%0d err=%b expected done err=0", d, o_err);
        end
    endtask

    task automatic test_abort();
        int c0, nst, fin0, abort_at, d;
        i_chp_cnt = 10'd8;
        i_frm_cnt = 4'd1;
        i_pingpong_en = 1'b0;
        core_en = 1'b1;
        fin0 = fin_total;
        nst = 0;
        abort_at = -1;
        d = -1;
        pulse_start(c0);
        for (int k = 0; k < 3000; k++) begin
            if (o_core_start) begin
                nst++;
                if (nst == 2) abort_at = cyc + 20;
            end
            if (o_done) begin
                d = cyc;
                break;
            end
            i_abort = (cyc == abort_at);
            step();
        end
        i_abort = 1'b0;
        checks++;
        if (d != fin_edge || fin_total - fin0 != 2) begin
            errors++;
            $display("[TB] FAIL abort_done: got cyc=%0d fins=%0d expected cyc=%0d fins=2", d, fin_total - fin0, fin_edge);
        end
        checks++;
        if (nst != 2 || o_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_starts: got starts=%0d err=%b expected 2 0", nst, o_err);
        end
    endtask

    task automatic test_ignore();
        logic [31:0] exp_q[$];
        int          idx_q[$];
        logic [31:0] e;
        int          c0, n_st, first_st, prev_st, fin0, ei, d;
        i_chp_cnt = 10'd3;
        i_frm_cnt = 4'd1;
        i_pingpong_en = 1'b1;
        core_en = 1'b1;
        fin0 = fin_total;
        n_st = 0;
        first_st = -100;
        prev_st = 0;
        d = -1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back((i % 2 == 1) ? 32'd49152 : 32'd16384);
            idx_q.push_back(i);
        end
        pulse_start(c0);
        for (int k = 0; k < 2000; k++) begin
            if (o_core_start) begin
                if (n_st == 0) first_st = cyc;
                checks++;
                if (n_st > 0 && cyc - prev_st != SPACING) begin
                    errors++;
                    $display("[TB] FAIL ignore_spacing: got %0d expected %0d", cyc - prev_st, SPACING);
                end
                prev_st = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL ignore_extra_start: got start %0d expected 3 starts", n_st + 1);
                end else begin
                    e  = exp_q.pop_front();
                    ei = idx_q.pop_front();
                    if (o_wr_base !== e || o_chp_idx !== 10'(ei) || o_frm_idx !== 4'd0) begin
                        errors++;
                        $display("[TB] FAIL ignore_pass: got wr=%0d chp=%0d frm=%0d expected wr=%0d chp=%0d frm=0",
                                 o_wr_base, o_chp_idx, o_frm_idx, e, ei);
                    end
                end
                n_st++;
            end
            if (o_done) begin
                d = cyc;
                break;
            end
            i_start   = (cyc == first_st + 20);
            stray_fin = (fin_total - fin0 == 1) && (cyc == fin_edge + 10);
            step();
        end
        i_start = 1'b0;
        stray_fin = 1'b0;
        checks++;
        if (n_st != 3 || d != fin_edge) begin
            errors++;
            $display("[TB] FAIL ignore_end: got starts=%0d done=%0d expected 3 %0d", n_st, d, fin_edge);
        end
    endtask

    task automatic test_reset_gap();
        int  c0, fin0, nst, busy_hi;
        bit  hit;
        i_chp_cnt = 10'd2;
        i_frm_cnt = 4'd1;
        i_pingpong_en = 1'b1;
        core_en = 1'b1;
        fin0 = fin_total;
        hit = 0;
        pulse_start(c0);
        for (int k = 0; k < 400; k++) begin
            if (fin_total - fin0 == 1 && cyc == fin_edge + 10) begin
                hit = 1;
                break;
            end
            step();
        end
        checks++;
        if (!hit || o_wr_base !== 32'd49152 || o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL gap_reached: got hit=%0d wr=%0d busy=%b expected 1 49152 1", hit, o_wr_base, o_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_wr_base !== 32'd16384 || o_rd_base !== 32'd0 || o_chp_idx !== 10'd0) begin
            errors++;
            $display("[TB] FAIL gap_async_reset: got busy=%b wr=%0d rd=%0d chp=%0d expected 0 16384 0 0",
                     o_busy, o_wr_base, o_rd_base, o_chp_idx);
        end
        step();
        rst_n = 1'b1;
        nst = 0;
        busy_hi = 0;
        for (int k = 0; k < 200; k++) begin
            if (o_core_start) nst++;
            if (o_busy) busy_hi++;
            step();
        end
        checks++;
        if (nst != 0 || busy_hi != 0) begin
            errors++;
            $display("[TB] FAIL gap_after_reset: got starts=%0d busy_cycles=%0d expected 0 0", nst, busy_hi);
        end
    endtask

    task automatic test_timeout();
        int c0, d, nst;
        core_en = 1'b0;
        i_chp_cnt = 10'd1;
        i_frm_cnt = 4'd1;
        i_pingpong_en = 1'b0;
        pulse_start(c0);
`ifdef RSP_S2_SCHED_TIMEOUT_EN
        wait_done(600, d, nst);
        checks++;
        if (d < 0 || d - (c0 + 2) < 198 || d - (c0 + 2) > 204) begin
            errors++;
            $display("[TB] FAIL timeout_done: got %0d cycles after start expected about 200", d - (c0 + 2));
        end
        checks++;
        if (o_err !== 1'b1 || nst != 1) begin
            errors++;
            $display("[TB] FAIL timeout_err: got err=%b starts=%0d expected 1 1", o_err, nst);
        end
`else
        d = 0;
        nst = 0;
        for (int k = 0; k < 400; k++) begin
            if (!o_busy) d++;
            if (o_done) nst++;
            step();
        end
        checks++;
        if (d != 0 || nst != 0 || o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL no_timeout_busy: got idle_cycles=%0d dones=%0d busy=%b expected 0 0 1", d, nst, o_busy);
        end
`endif
        core_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_main();
        test_zero_count();
        test_abort();
        test_ignore();
        test_reset_gap();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
